piso_squeeze_ctrl: RTL and testbench
====================================

// Module: piso_squeeze_ctrl
// PURPOSE
//   Sequences the Keccak squeeze phase through the piso_buffer that serialises the rate
//   portion of the state. Takes a requested output length in words, then repeats:
//   accept a rate block from the permutation core, parallel-load it into the PISO, and
//   shift it out one WIDTH-bit word per valid/ready beat. When a block is exhausted and
//   words remain, it requests another permutation. Sits between the Keccak core and
//   the output stream.
// PARAMETERS
//   WIDTH  64  word/lane width; must equal the piso_buffer WIDTH
//   DEPTH  21  words per rate block; must equal piso_buffer DEPTH (21 = SHAKE128, 17 = SHAKE256)
//   LEN_W  16  width of the output-length field in words
// PORTS
//   clk          in   1      clock, rising edge
//   rst          in   1      asynchronous reset, active-high
//   start        in   1      begin squeeze; sampled only in IDLE
//   len_words    in   LEN_W  total output words; latched when start is accepted
//   block_valid  in   1      core presents a permuted state block
//   block_ready  out  1      controller accepts the block; the PISO loads on valid&ready
//   perm_next    out  1      1-cycle pulse: core must run another permutation
//   piso_en      out  1      to piso_buffer en
//   piso_sel     out  1      to piso_buffer sel (0 = parallel load, 1 = shift)
//   dout_valid   out  1      piso data_out holds a valid output word
//   dout_ready   in   1      downstream accepts the word
//   dout_last    out  1      current word is the final word of the request
//   busy         out  1      high in every state except IDLE
//   done         out  1      1-cycle pulse when the request completes
// BEHAVIOUR
//   - States: IDLE, WAIT_BLK, SHIFT, FIN. Reset (async) forces IDLE and clears remain,
//     lane_cnt, perm_next and done. With reset asserted, every output is 0.
//   - IDLE: when start=1 and len_words!=0, latch remain=len_words and go to WAIT_BLK.
//     When start=1 and len_words==0, go to FIN. No block is consumed in that case.
//   - WAIT_BLK: block_ready=1 (Moore). On block_valid=1, drive piso_en=1 and piso_sel=0
//     in the same cycle (Mealy), clear lane_cnt, and go to SHIFT.
//   - SHIFT: dout_valid=1 (Moore). The first word appears the cycle after the load. On
//     dout_valid&dout_ready, drive piso_en=1 and piso_sel=1 (Mealy), then:
//       * if remain==1, go to FIN;
//       * else if lane_cnt==DEPTH-1, go to WAIT_BLK with perm_next=1 for exactly 1 cycle;
//       * else increment lane_cnt.
//     In all three cases remain decrements by 1.
//   - If dout_ready=0: piso_en=0, so the word and all counters hold. Downstream may
//     stall for any number of cycles.
//   - dout_last = (state==SHIFT) && (remain==1).
//   - FIN: done=1 for one cycle, then go to IDLE. busy=0 only in IDLE.
//   - piso_en=0 in IDLE and FIN, and in WAIT_BLK without block_valid. The PISO is never
//     shifted outside a handshake.
//   - Word order: the first word out is block lane DEPTH-1, i.e.
//     data_in[(DEPTH-1)*WIDTH +: WIDTH], and lane 0 comes out last.
//   - A partial final block leaves unread lanes in the PISO. They are discarded, not flushed.
//   - In any state other than IDLE, start is ignored. In states other than WAIT_BLK,
//     block_valid is ignored.
//   - Reset mid-operation aborts immediately. There is no done pulse, and PISO contents
//     are don't-care.
//   - Widths: remain is LEN_W bits and lane_cnt is $clog2(DEPTH) bits. A len_words value
//     of 2^LEN_W-1 is legal.
// TESTING
//   1. DEPTH=4, len=3, dout_ready=1 held: one block load -> 3 beats, lanes 3,2,1;
//      dout_last on beat 3; done 1 cycle later; perm_next never asserts.
//   2. DEPTH=4, len=10: three loads, perm_next pulsed exactly twice;
//      10 beats = 4+4+2; dout_last only on beat 10.
//   3. len=0 with start: done pulses within 2 cycles; block_ready, piso_en and
//      dout_valid stay 0.
//   4. Random dout_ready (~50%) with len=45 and DEPTH=21: word sequence matches the
//      model; the PISO shifts only on handshake cycles; remain never underflows.
//   5. block_valid delayed by 7 cycles in WAIT_BLK: dout_valid stays low and piso_en
//      stays low until the load.
//   6. rst asserted in the middle of the second block: all outputs 0 asynchronously.
//      Then start with len=2: normal completion with no residue from the aborted request.

Source files
------------

// File: rtl/piso_squeeze_ctrl.sv
// piso_squeeze_ctrl: sequences Keccak squeeze blocks through a PISO, one word per valid/ready beat.
module piso_squeeze_ctrl #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 21,
    parameter int LEN_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [LEN_W-1:0] len_words,
    input  logic             block_valid,
    output logic             block_ready,
    output logic             perm_next,
    output logic             piso_en,
    output logic             piso_sel,
    output logic             dout_valid,
    input  logic             dout_ready,
    output logic             dout_last,
    output logic             busy,
    output logic             done
);
    localparam int LC_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [LC_W-1:0] LAST_LANE = LC_W'(DEPTH - 1);
    localparam logic [1:0] IDLE = 2'd0, WAIT_BLK = 2'd1, SHIFT = 2'd2, FIN = 2'd3;

    if (WIDTH < 1 || DEPTH < 2 || LEN_W < 1) begin : g_bad_params
        $error("piso_squeeze_ctrl: WIDTH>=1, DEPTH>=2 and LEN_W>=1 required");
    end

    logic [1:0]       state;
    logic [LEN_W-1:0] remain;
    logic [LC_W-1:0]  lane_cnt;
    logic             load, shift;

    assign load        = (state == WAIT_BLK) && block_valid;
    assign shift       = (state == SHIFT) && dout_ready;
    assign block_ready = state == WAIT_BLK;
    assign dout_valid  = state == SHIFT;
    assign piso_en     = load || shift;
    assign piso_sel    = shift;
    assign dout_last   = dout_valid && (remain == LEN_W'(1));
    assign busy        = state != IDLE;
    assign done        = state == FIN;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            remain    <= '0;
            lane_cnt  <= '0;
            perm_next <= 1'b0;
        end else begin
            perm_next <= 1'b0;
            case (state)
                IDLE: if (start) begin
                    remain <= len_words;
                    state  <= (len_words != '0) ? WAIT_BLK : FIN;
                end
                WAIT_BLK: if (block_valid) begin
                    lane_cnt <= '0;
                    state    <= SHIFT;
                end
                SHIFT: if (dout_ready) begin
                    remain <= remain - LEN_W'(1);
                    if (remain == LEN_W'(1)) begin
                        state <= FIN;
                    end else if (lane_cnt == LAST_LANE) begin
                        // block exhausted with words still owed: ask the core for more state
                        state     <= WAIT_BLK;
                        perm_next <= 1'b1;
                    end else begin
                        lane_cnt <= lane_cnt + LC_W'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_piso_squeeze_ctrl.sv
// tb_piso_squeeze_ctrl: directed scoreboard bench for the squeeze controller at DEPTH=4 and DEPTH=21.
module tb_piso_squeeze_ctrl;
    localparam int W = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic        start [2];
    logic        block_valid [2];
    logic        dout_ready [2];
    logic [15:0] len_words [2];
    logic        block_ready [2];
    logic        perm_next [2];
    logic        piso_en [2];
    logic        piso_sel [2];
    logic        dout_valid [2];
    logic        dout_last [2];
    logic        busy [2];
    logic        done [2];
    logic [21*W-1:0] blk [2];
    logic [21*W-1:0] sreg [2];

    piso_squeeze_ctrl #(.WIDTH(W), .DEPTH(4), .LEN_W(16)) u_d4 (
        .clk(clk), .rst(rst), .start(start[0]), .len_words(len_words[0]),
        .block_valid(block_valid[0]), .block_ready(block_ready[0]), .perm_next(perm_next[0]),
        .piso_en(piso_en[0]), .piso_sel(piso_sel[0]), .dout_valid(dout_valid[0]),
        .dout_ready(dout_ready[0]), .dout_last(dout_last[0]), .busy(busy[0]), .done(done[0]));

    piso_squeeze_ctrl #(.WIDTH(W), .DEPTH(21), .LEN_W(16)) u_d21 (
        .clk(clk), .rst(rst), .start(start[1]), .len_words(len_words[1]),
        .block_valid(block_valid[1]), .block_ready(block_ready[1]), .perm_next(perm_next[1]),
        .piso_en(piso_en[1]), .piso_sel(piso_sel[1]), .dout_valid(dout_valid[1]),
        .dout_ready(dout_ready[1]), .dout_last(dout_last[1]), .busy(busy[1]), .done(done[1]));

    // Behavioural piso_buffer: load on en&!sel, shift toward the top lane on en&sel.
    always_ff @(posedge clk)
        for (int i = 0; i < 2; i++)
            if (piso_en[i]) sreg[i] <= piso_sel[i] ? (sreg[i] << W) : blk[i];

    function automatic logic [W-1:0] dout_of(int i);
        return (i == 0) ? sreg[0][3*W +: W] : sreg[1][20*W +: W];
    endfunction

    int errors = 0;
    int checks = 0;
    logic [W-1:0] q[$];

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] outs(int i);
        return {block_ready[i], perm_next[i], piso_en[i], piso_sel[i],
                dout_valid[i], dout_last[i], busy[i], done[i]};
    endfunction

    task automatic run(int i, int len, int bv_delay, bit rnd, int abort_beat, int dep);
        int beats = 0, loads = 0, perms = 0, pushed = 0, wait_c = 0;
        int cyc = 0, last_cyc = -1, done_cyc = -1;
        bit aborted = 0;
        logic [W-1:0] exp_w;
        q.delete();
        @(negedge clk);
        start[i] = 1'b1;
        len_words[i] = 16'(len);
        #1 chk("idle_en", 32'(piso_en[i]), 0);
        @(negedge clk);
        start[i] = 1'b0;
        cyc = 1;
        while (done_cyc < 0 && cyc < 3000) begin
            block_valid[i] = block_ready[i] && (wait_c >= bv_delay);
            if (block_valid[i])
                for (int k = 0; k < 21; k++) blk[i][k*W +: W] = W'($urandom);
            dout_ready[i] = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            #1;
            if (perm_next[i]) perms++;
            if (block_valid[i]) begin
                chk("load_en", 32'(piso_en[i]), 1);
                chk("load_sel", 32'(piso_sel[i]), 0);
                loads++;
                for (int k = dep - 1; k >= 0 && pushed < len; k--) begin
                    q.push_back(blk[i][k*W +: W]);
                    pushed++;
                end
            end else if (dout_valid[i]) begin
                chk("dout_last", 32'(dout_last[i]), 32'(beats + 1 == len));
                if (dout_ready[i]) begin
                    chk("shift_en", 32'(piso_en[i]), 1);
                    chk("shift_sel", 32'(piso_sel[i]), 1);
                    if (q.size() == 0) chk("queue_underflow", 32'(q.size()), 1);
                    else begin
                        exp_w = q.pop_front();
                        chk("word", 32'(dout_of(i)), 32'(exp_w));
                    end
                    beats++;
                    last_cyc = cyc;
                    if (beats == abort_beat) begin
                        aborted = 1;
                        break;
                    end
                end else chk("stall_en", 32'(piso_en[i]), 0);
            end else chk("nohs_en", 32'(piso_en[i]), 0);
            if (done[i]) done_cyc = cyc;
            wait_c = block_ready[i] ? wait_c + 1 : 0;
            @(negedge clk);
            cyc++;
        end
        block_valid[i] = 1'b0;
        if (aborted) begin
            @(posedge clk);
            #2;
            dout_ready[i] = 1'b0;
            chk("pre_rst_busy", 32'(busy[i]), 1);
            rst = 1'b1;
            #1 chk("rst_outputs", 32'(outs(i)), 0);
            @(negedge clk);
            rst = 1'b0;
            q.delete();
            return;
        end
        dout_ready[i] = 1'b0;
        chk("done_seen", 32'(done_cyc >= 0), 1);
        chk("beats", 32'(beats), 32'(len));
        chk("loads", 32'(loads), 32'((len + dep - 1) / dep));
        chk("perm_pulses", 32'(perms), 32'((len == 0) ? 0 : (len + dep - 1) / dep - 1));
        chk("queue_empty", 32'(q.size()), 0);
        if (len == 0) chk("done_fast", 32'(done_cyc <= 2), 1);
        else chk("done_latency", 32'(done_cyc), 32'(last_cyc + 1));
        #1;
        chk("done_drop", 32'(done[i]), 0);
        chk("busy_drop", 32'(busy[i]), 0);
    endtask

    initial begin
        for (int i = 0; i < 2; i++) begin
            start[i] = 1'b0;
            block_valid[i] = 1'b0;
            dout_ready[i] = 1'b0;
            len_words[i] = '0;
            blk[i] = '0;
        end
        #2;
        chk("reset_outs_d4", 32'(outs(0)), 0);
        chk("reset_outs_d21", 32'(outs(1)), 0);
        @(negedge clk);
        rst = 1'b0;
        run(0, 3, 0, 0, 0, 4);
        run(0, 10, 0, 0, 0, 4);
        run(0, 0, 0, 0, 0, 4);
        run(1, 45, 0, 1, 0, 21);
        run(1, 21, 3, 1, 0, 21);
        run(0, 5, 7, 0, 0, 4);
        run(0, 10, 0, 0, 6, 4);
        run(0, 2, 0, 0, 0, 4);
        run(0, 9, 2, 1, 0, 4);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
